// File: rtl/mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_mem_responder
//
// Byte-wide memory responder for the far side of the multicycle MIPS
// controller's memory interface. Services read (instruction fetch / LB) and
// write (SB) requests from an internal byte array. A parameterised number of
// wait states is inserted between request capture and response. Completion is
// signalled with a one-cycle memready pulse. A boot-load port fills the array
// while the processor side is held in reset.
//
// Parameters:
//   WIDTH      - data byte width
//   ADDR_WIDTH - address width, array depth is 2**ADDR_WIDTH
//   WAIT       - wait states between capture and response (0..15)
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous, active-high
//   memread    in   read request, held until memready
//   memwrite   in   write request, held until memready
//   adr        in   byte address, captured at acceptance
//   writedata  in   store byte, captured at acceptance
//   memdata    out  registered read data, holds until the next completed read
//   memready   out  one-cycle completion pulse
//   err        out  one-cycle pulse when read and write are accepted together
//   load_en    in   boot-load strobe, only honored while reset is high
//   load_adr   in   boot-load address
//   load_data  in   boot-load byte
// ---------------------------------------------------------------------------
module mips_mem_responder #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [WIDTH-1:0]      writedata,
    output logic [WIDTH-1:0]      memdata,
    output logic                  memready,
    output logic                  err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_adr,
    input  logic [WIDTH-1:0]      load_data
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_op_wr;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_mem [2**ADDR_WIDTH];

    // The request line that belongs to the captured operation; dropping it
    // during WAIT or RESP aborts the transaction.
    logic w_req_live;
    logic w_commit_wr;

    assign w_req_live  = r_op_wr ? memwrite : memread;
    assign w_commit_wr = (r_state == S_RESP) && r_op_wr && memwrite && !reset;

    // Storage array is never cleared. Boot-load owns the write port during
    // reset; otherwise only a live write in RESP commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (load_en) begin
                r_mem[load_adr] <= load_data;
            end
        end else if (w_commit_wr) begin
            r_mem[r_adr] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_op_wr  <= 1'b0;
            r_adr    <= '0;
            r_data   <= '0;
            memdata  <= '0;
            memready <= 1'b0;
            err      <= 1'b0;
        end else begin
            memready <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (memread || memwrite) begin
                        r_adr   <= adr;
                        r_data  <= writedata;
                        // A simultaneous read+write is treated as a write.
                        r_op_wr <= memwrite;
                        r_cnt   <= WAIT_CNT;
                        err     <= memread && memwrite;
                        r_state <= (WAIT_CNT != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!w_req_live) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        // Counter starts at WAIT, so this gives WAIT cycles here.
                        if (r_cnt == 4'd1) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (w_req_live) begin
                        if (!r_op_wr) begin
                            memdata <= r_mem[r_adr];
                        end
                        memready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_responder
//
// Directed bench for mips_mem_responder. Four instances with WAIT = 0, 2, 3
// and 5 share clock, reset and request inputs; each scenario looks only at
// the instance whose wait count it exercises. Every scenario begins with a
// reset window so all instances start from IDLE and boot-load data is set.
// ---------------------------------------------------------------------------
module tb_mips_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       memread;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       load_en;
    logic [7:0] load_adr;
    logic [7:0] load_data;

    // Instance index: 0 -> WAIT 0, 1 -> WAIT 2, 2 -> WAIT 3, 3 -> WAIT 5
    logic [7:0] md   [4];
    logic       rdy  [4];
    logic       errv [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_mem_responder #(.WIDTH(8), .ADDR_WIDTH(8), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md[0]), .memready(rdy[0]),
        .err(errv[0]), .load_en(load_en), .load_adr(load_adr), .load_data(load_data));

    mips_mem_responder #(.WIDTH(8), .ADDR_WIDTH(8), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md[1]), .memready(rdy[1]),
        .err(errv[1]), .load_en(load_en), .load_adr(load_adr), .load_data(load_data));

    mips_mem_responder #(.WIDTH(8), .ADDR_WIDTH(8), .WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md[2]), .memready(rdy[2]),
        .err(errv[2]), .load_en(load_en), .load_adr(load_adr), .load_data(load_data));

    mips_mem_responder #(.WIDTH(8), .ADDR_WIDTH(8), .WAIT(5)) u_w5 (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md[3]), .memready(rdy[3]),
        .err(errv[3]), .load_en(load_en), .load_adr(load_adr), .load_data(load_data));

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boot_load(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_adr  = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // One request on instance k with w wait states. The request is accepted
    // on the first edge; adr/writedata are scrambled right after acceptance.
    // The request is dropped before edge drop_at (0 = normal completion,
    // dropped right after the memready cycle). Reports memready count, the
    // edge index of the first memready, memdata at that point and err count.
    task automatic xact(input int k, input int w, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d, input int drop_at,
                        output int n_rdy, output int rdy_cyc,
                        output logic [7:0] mdv, output int n_err);
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = d;
        n_rdy     = 0;
        rdy_cyc   = -1;
        n_err     = 0;
        mdv       = md[k];
        tick();
        adr       = a + 8'h01;
        writedata = ~d;
        if (errv[k]) n_err++;
        if (rdy[k]) n_rdy++;
        for (int c = 1; c <= w + 3; c++) begin
            if (c == drop_at || c == w + 2) begin
                memread  = 1'b0;
                memwrite = 1'b0;
            end
            tick();
            if (errv[k]) n_err++;
            if (rdy[k]) begin
                n_rdy++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    mdv     = md[k];
                end
            end
        end
        if (rdy_cyc < 0) mdv = md[k];
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        memread  = 1'b1;
        memwrite = 1'b0;
        tick();
        tick();
        memread  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_memready[%0d]: got %b want 0", k, rdy[k]);
            end
            checks++;
            if (errv[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err[%0d]: got %b want 0", k, errv[k]);
            end
            checks++;
            if (md[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_memdata[%0d]: got %h want 00", k, md[k]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_boot_read();
        logic [7:0] exp_b [4];
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        exp_b[0] = 8'h20; exp_b[1] = 8'h07; exp_b[2] = 8'h00; exp_b[3] = 8'h05;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) boot_load(8'(i), exp_b[i]);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            xact(0, 0, 1'b1, 1'b0, 8'(i), 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
            checks++;
            if (n_rdy != 1 || rdy_cyc != 1) begin
                errors++;
                $display("FAIL boot_read_ready[%0d]: got count=%0d at=%0d want count=1 at=1",
                         i, n_rdy, rdy_cyc);
            end
            checks++;
            if (mdv !== exp_b[i]) begin
                errors++;
                $display("FAIL boot_read_data[%0d]: got %h want %h", i, mdv, exp_b[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        reset = 1'b1;
        boot_load(8'h10, 8'hA5);
        boot_load(8'h11, 8'h5A);
        reset = 1'b0;
        tick();
        xact(2, 3, 1'b1, 1'b0, 8'h10, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || rdy_cyc != 4) begin
            errors++;
            $display("FAIL wait3_ready: got count=%0d at=%0d want count=1 at=4", n_rdy, rdy_cyc);
        end
        checks++;
        if (mdv !== 8'hA5) begin
            errors++;
            $display("FAIL wait3_data: got %h want a5", mdv);
        end
    endtask

    task automatic test_store_load();
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        reset = 1'b1;
        boot_load(8'h81, 8'h6B);
        reset = 1'b0;
        tick();
        xact(0, 0, 1'b1, 1'b0, 8'h81, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (mdv !== 8'h6B) begin
            errors++;
            $display("FAIL store_pre_read: got %h want 6b", mdv);
        end
        xact(0, 0, 1'b0, 1'b1, 8'h80, 8'h3C, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || rdy_cyc != 1) begin
            errors++;
            $display("FAIL store_ready: got count=%0d at=%0d want count=1 at=1", n_rdy, rdy_cyc);
        end
        checks++;
        if (mdv !== 8'h6B) begin
            errors++;
            $display("FAIL store_memdata_hold: got %h want 6b", mdv);
        end
        xact(0, 0, 1'b1, 1'b0, 8'h80, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || mdv !== 8'h3C) begin
            errors++;
            $display("FAIL load_after_store: got count=%0d data=%h want count=1 data=3c", n_rdy, mdv);
        end
    endtask

    task automatic test_abort();
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        reset = 1'b1;
        boot_load(8'h40, 8'h11);
        reset = 1'b0;
        tick();
        xact(1, 2, 1'b0, 1'b1, 8'h40, 8'h55, 2, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 0) begin
            errors++;
            $display("FAIL abort_no_ready: got count=%0d want 0", n_rdy);
        end
        xact(1, 2, 1'b1, 1'b0, 8'h40, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || rdy_cyc != 3) begin
            errors++;
            $display("FAIL abort_next_ready: got count=%0d at=%0d want count=1 at=3", n_rdy, rdy_cyc);
        end
        checks++;
        if (mdv !== 8'h11) begin
            errors++;
            $display("FAIL abort_no_commit: got %h want 11", mdv);
        end
    endtask

    task automatic test_conflict();
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        reset = 1'b1;
        boot_load(8'h20, 8'h00);
        reset = 1'b0;
        tick();
        xact(0, 0, 1'b1, 1'b1, 8'h20, 8'h99, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_err != 1) begin
            errors++;
            $display("FAIL conflict_err: got count=%0d want 1", n_err);
        end
        checks++;
        if (n_rdy != 1 || rdy_cyc != 1) begin
            errors++;
            $display("FAIL conflict_ready: got count=%0d at=%0d want count=1 at=1", n_rdy, rdy_cyc);
        end
        xact(0, 0, 1'b1, 1'b0, 8'h20, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (mdv !== 8'h99 || n_err != 0) begin
            errors++;
            $display("FAIL conflict_written: got data=%h err=%0d want data=99 err=0", mdv, n_err);
        end
    endtask

    task automatic test_reset_midop();
        int         n_rdy, rdy_cyc, n_err;
        logic [7:0] mdv;
        reset = 1'b1;
        boot_load(8'h30, 8'h44);
        boot_load(8'h31, 8'h77);
        reset = 1'b0;
        tick();
        xact(3, 5, 1'b1, 1'b0, 8'h31, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || rdy_cyc != 6 || mdv !== 8'h77) begin
            errors++;
            $display("FAIL wait5_read: got count=%0d at=%0d data=%h want count=1 at=6 data=77",
                     n_rdy, rdy_cyc, mdv);
        end
        memwrite  = 1'b1;
        adr       = 8'h30;
        writedata = 8'hEE;
        tick();
        tick();
        reset    = 1'b1;
        memwrite = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (rdy[3] !== 1'b0 || errv[3] !== 1'b0 || md[3] !== 8'h00) begin
            errors++;
            $display("FAIL midop_reset_outputs: got ready=%b err=%b data=%h want 0 0 00",
                     rdy[3], errv[3], md[3]);
        end
        // load_en outside reset must not touch the array
        load_en   = 1'b1;
        load_adr  = 8'h30;
        load_data = 8'hBB;
        tick();
        load_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (rdy[3] !== 1'b0) begin
                errors++;
                $display("FAIL midop_stray_ready[%0d]: got %b want 0", c, rdy[3]);
            end
        end
        xact(3, 5, 1'b1, 1'b0, 8'h30, 8'h00, 0, n_rdy, rdy_cyc, mdv, n_err);
        checks++;
        if (n_rdy != 1 || mdv !== 8'h44) begin
            errors++;
            $display("FAIL midop_target_kept: got count=%0d data=%h want count=1 data=44", n_rdy, mdv);
        end
    endtask

    initial begin
        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        adr       = 8'h00;
        writedata = 8'h00;
        load_en   = 1'b0;
        load_adr  = 8'h00;
        load_data = 8'h00;
        test_reset();
        test_boot_read();
        test_wait_states();
        test_store_load();
        test_abort();
        test_conflict();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
